// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the multicycle ALU: opcodes, status bit positions, FSM states.
package alu_multicycle_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_ADDU  = 4'd1;
    localparam logic [3:0] OP_ADDC  = 4'd2;
    localparam logic [3:0] OP_ADDCU = 4'd3;
    localparam logic [3:0] OP_MUL   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_NOT   = 4'd6;
    localparam logic [3:0] OP_AND   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_XOR   = 4'd9;
    localparam logic [3:0] OP_LSH   = 4'd10;
    localparam logic [3:0] OP_RSH   = 4'd11;
    localparam logic [3:0] OP_ALSH  = 4'd12;
    localparam logic [3:0] OP_ARSH  = 4'd13;
    localparam logic [3:0] OP_DIVU  = 4'd14;
    localparam logic [3:0] OP_RSVD  = 4'd15;

    localparam int STATUS_INDEX_CARRY = 0;
    localparam int STATUS_INDEX_LOW   = 1;
    localparam int STATUS_INDEX_FLAG  = 2;
    localparam int STATUS_INDEX_ZERO  = 3;
    localparam int STATUS_INDEX_NEG   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_multicycle_iter_muldiv.sv
// Iterative datapath: signed shift-add multiplier on magnitudes and unsigned restoring divider.
// Both share one {acc, lq} shift pair; the sign fix-up is applied combinationally on the result.
module alu_iter_muldiv
    import alu_multicycle_pkg::*;
#(
    parameter int P_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               div_sel,
    input  logic               step,
    input  logic [P_WIDTH-1:0] a,
    input  logic [P_WIDTH-1:0] b,
    output logic               last,
    output logic               div_mode,
    output logic               div_zero,
    output logic [P_WIDTH-1:0] res_lo,
    output logic [P_WIDTH-1:0] res_hi
);

    localparam int CW = $clog2(P_WIDTH + 1);

    logic [P_WIDTH:0]     acc;
    logic [P_WIDTH-1:0]   lq;
    logic [P_WIDTH-1:0]   opb;
    logic [CW-1:0]        cnt;
    logic                 neg;

    logic [P_WIDTH:0]     shifted;
    logic [P_WIDTH:0]     mac;
    logic                 ge;
    logic [2*P_WIDTH-1:0] prod;

    always_comb begin
        shifted = {acc[P_WIDTH-1:0], lq[P_WIDTH-1]};
        ge      = shifted >= {1'b0, opb};
        mac     = acc + (lq[0] ? {1'b0, opb} : '0);
        prod    = {acc[P_WIDTH-1:0], lq};
    end

    // neg is only ever set for MUL, so the divider result passes straight through
    assign {res_hi, res_lo} = neg ? (2*P_WIDTH)'(0) - prod : prod;
    assign last = (cnt == CW'(P_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            lq       <= '0;
            opb      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            div_mode <= 1'b0;
            div_zero <= 1'b0;
        end else if (load) begin
            acc      <= '0;
            cnt      <= '0;
            div_mode <= div_sel;
            div_zero <= (b == '0);
            if (div_sel) begin
                lq  <= a;
                opb <= b;
                neg <= 1'b0;
            end else begin
                lq  <= a[P_WIDTH-1] ? P_WIDTH'(0) - a : a;
                opb <= b[P_WIDTH-1] ? P_WIDTH'(0) - b : b;
                neg <= a[P_WIDTH-1] ^ b[P_WIDTH-1];
            end
        end else if (step) begin
            cnt <= cnt + 1'b1;
            if (div_mode) begin
                // divide by zero naturally yields quotient all ones and remainder = dividend
                acc <= ge ? shifted - {1'b0, opb} : shifted;
                lq  <= {lq[P_WIDTH-2:0], ge};
            end else begin
                acc <= {1'b0, mac[P_WIDTH:1]};
                lq  <= {mac[0], lq[P_WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Registered, handshaked ALU: single-cycle ops finish next cycle, MUL/DIVU iterate
// for P_WIDTH cycles plus one fix-up cycle while O_BUSY is high.
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int P_WIDTH = 16
) (
    input  logic               I_CLK,
    input  logic               I_RESET,
    input  logic               I_START,
    input  logic [3:0]         I_OPCODE,
    input  logic [P_WIDTH-1:0] I_A,
    input  logic [P_WIDTH-1:0] I_B,
    output logic               O_BUSY,
    output logic               O_DONE,
    output logic [P_WIDTH-1:0] O_C,
    output logic [P_WIDTH-1:0] O_C_HI,
    output logic [4:0]         O_STATUS
);

    state_t state, state_nxt;

    logic               accept;
    logic               iter_op;
    logic               iter_last;
    logic               div_mode;
    logic               div_zero;
    logic [P_WIDTH-1:0] md_lo, md_hi;
    logic [4:0]         md_st;

    logic [P_WIDTH:0]   sum;
    logic               cin;
    logic [P_WIDTH-1:0] sc_c;
    logic [4:0]         sc_st;

    assign accept  = I_START && (state == S_IDLE);
    assign iter_op = (I_OPCODE == OP_MUL) || (I_OPCODE == OP_DIVU);
    assign O_BUSY  = (state != S_IDLE);

    alu_iter_muldiv #(.P_WIDTH(P_WIDTH)) u_iter (
        .clk      (I_CLK),
        .reset    (I_RESET),
        .load     (accept && iter_op),
        .div_sel  (I_OPCODE == OP_DIVU),
        .step     (state == S_ITER),
        .a        (I_A),
        .b        (I_B),
        .last     (iter_last),
        .div_mode (div_mode),
        .div_zero (div_zero),
        .res_lo   (md_lo),
        .res_hi   (md_hi)
    );

    always_ff @(posedge I_CLK) begin
        if (I_RESET) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && iter_op) state_nxt = S_ITER;
            S_ITER:  if (iter_last) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cin   = (I_OPCODE == OP_ADDC) || (I_OPCODE == OP_ADDCU);
        sum   = {1'b0, I_A} + {1'b0, I_B} + {{P_WIDTH{1'b0}}, cin};
        sc_c  = '0;
        sc_st = '0;
        case (I_OPCODE)
            OP_ADD, OP_ADDC: begin
                sc_c = sum[P_WIDTH-1:0];
                sc_st[STATUS_INDEX_FLAG] = (I_A[P_WIDTH-1] == I_B[P_WIDTH-1]) &&
                                           (sc_c[P_WIDTH-1] != I_A[P_WIDTH-1]);
                sc_st[STATUS_INDEX_NEG]  = sc_c[P_WIDTH-1];
            end
            OP_ADDU, OP_ADDCU: begin
                sc_c = sum[P_WIDTH-1:0];
                sc_st[STATUS_INDEX_CARRY] = sum[P_WIDTH];
            end
            OP_SUB: begin
                sc_c = I_B - I_A;
                sc_st[STATUS_INDEX_CARRY] = I_B < I_A;
                sc_st[STATUS_INDEX_LOW]   = I_B < I_A;
                sc_st[STATUS_INDEX_FLAG]  = (I_A[P_WIDTH-1] != I_B[P_WIDTH-1]) &&
                                            (I_A[P_WIDTH-1] == sc_c[P_WIDTH-1]);
                sc_st[STATUS_INDEX_NEG]   = $signed(I_B) < $signed(I_A);
            end
            OP_NOT:          sc_c = ~I_A;
            OP_AND:          sc_c = I_A & I_B;
            OP_OR:           sc_c = I_A | I_B;
            OP_XOR:          sc_c = I_A ^ I_B;
            OP_LSH, OP_ALSH: sc_c = I_A << I_B;
            OP_RSH:          sc_c = I_A >> I_B;
            OP_ARSH:         sc_c = $signed(I_A) >>> I_B;
            default:         sc_c = '0;
        endcase
        if (!(I_OPCODE inside {OP_MUL, OP_DIVU, OP_RSVD}))
            sc_st[STATUS_INDEX_ZERO] = (sc_c == '0);
    end

    always_comb begin
        md_st = '0;
        if (div_mode) begin
            md_st[STATUS_INDEX_ZERO] = (md_lo == '0);
            md_st[STATUS_INDEX_FLAG] = div_zero;
        end
    end

    // Outputs change only on a completion; they hold while an iterative op runs.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            O_DONE   <= 1'b0;
            O_C      <= '0;
            O_C_HI   <= '0;
            O_STATUS <= '0;
        end else begin
            O_DONE <= 1'b0;
            if (accept && !iter_op) begin
                O_DONE   <= 1'b1;
                O_C      <= sc_c;
                O_C_HI   <= '0;
                O_STATUS <= sc_st;
            end else if (state == S_FIX) begin
                O_DONE   <= 1'b1;
                O_C      <= md_lo;
                O_C_HI   <= md_hi;
                O_STATUS <= md_st;
            end
        end
    end

endmodule
